// File: rtl/regfile_2w2r.sv
// ============================================================================
// regfile_2w2r : 2**ADDR_W x DATA_W register file, two combinational read
//                ports, two clocked write lanes (lane 1 wins on collision).
// Optional build macro: REGFILE_BYPASS_EN (write-through read forwarding).
// Revision     : 1.0
// ============================================================================
`default_nettype none

module regfile_2w2r #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rdAddrA,
  output logic [DATA_W-1:0] rdDataA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [DATA_W-1:0] rdDataB,
  input  logic              write0,
  input  logic [ADDR_W-1:0] wrAddr0,
  input  logic [DATA_W-1:0] wrData0,
  input  logic              write1,
  input  logic [ADDR_W-1:0] wrAddr1,
  input  logic [DATA_W-1:0] wrData1,
  input  logic              clear,
  output logic              wrConflict
);

  localparam int              NUM_REGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '1;
  localparam logic            ZERO_EN   = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_conflict_q;
  logic              wr_conflict_d;
  logic              lane0_ok;
  logic              lane1_ok;

  assign lane0_ok = write0 && !(ZERO_EN && (wrAddr0 == ZERO_ADDR));
  assign lane1_ok = write1 && !(ZERO_EN && (wrAddr1 == ZERO_ADDR));

  // Lane 1 is applied last so it overwrites lane 0 on a shared address.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = '0;
      end
    end else begin
      if (lane0_ok) regs_d[wrAddr0] = wrData0;
      if (lane1_ok) regs_d[wrAddr1] = wrData1;
    end
  end

  assign wr_conflict_d = write0 && write1 && (wrAddr0 == wrAddr1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wrConflict = wr_conflict_q;

  always_comb begin
    rdDataA = regs_q[rdAddrA];
`ifdef REGFILE_BYPASS_EN
    if (!clear) begin
      if (write0 && (wrAddr0 == rdAddrA)) rdDataA = wrData0;
      if (write1 && (wrAddr1 == rdAddrA)) rdDataA = wrData1;
    end
`else
`endif
    if (ZERO_EN && (rdAddrA == ZERO_ADDR)) rdDataA = '0;
    if (!reset) rdDataA = '0;
  end

  always_comb begin
    rdDataB = regs_q[rdAddrB];
`ifdef REGFILE_BYPASS_EN
    if (!clear) begin
      if (write0 && (wrAddr0 == rdAddrB)) rdDataB = wrData0;
      if (write1 && (wrAddr1 == rdAddrB)) rdDataB = wrData1;
    end
`else
`endif
    if (ZERO_EN && (rdAddrB == ZERO_ADDR)) rdDataB = '0;
    if (!reset) rdDataB = '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_2w2r.sv
// ============================================================================
// tb_regfile_2w2r : directed self-checking bench for regfile_2w2r
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_2w2r;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] rdAddrA;
  logic [DATA_W-1:0] rdDataA;
  logic [ADDR_W-1:0] rdAddrB;
  logic [DATA_W-1:0] rdDataB;
  logic              write0;
  logic [ADDR_W-1:0] wrAddr0;
  logic [DATA_W-1:0] wrData0;
  logic              write1;
  logic [ADDR_W-1:0] wrAddr1;
  logic [DATA_W-1:0] wrData1;
  logic              clear;
  logic              wrConflict;

  int checks = 0;
  int errors = 0;

  regfile_2w2r #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .rdAddrA(rdAddrA), .rdDataA(rdDataA),
    .rdAddrB(rdAddrB), .rdDataB(rdDataB),
    .write0(write0), .wrAddr0(wrAddr0), .wrData0(wrData0),
    .write1(write1), .wrAddr1(wrAddr1), .wrData1(wrData1),
    .clear(clear), .wrConflict(wrConflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    write0 = 1'b0; wrAddr0 = '0; wrData0 = '0;
    write1 = 1'b0; wrAddr1 = '0; wrData1 = '0;
    clear  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    rdAddrA = 5'd0; rdAddrB = 5'd30;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdDataA !== 64'h0) begin errors++; $display("FAIL reset_rdA_held got %h exp %h", rdDataA, 64'h0); end
    checks++; if (rdDataB !== 64'h0) begin errors++; $display("FAIL reset_rdB_held got %h exp %h", rdDataB, 64'h0); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdDataA !== 64'h0) begin errors++; $display("FAIL reset_rdA got %h exp %h", rdDataA, 64'h0); end
    checks++; if (rdDataB !== 64'h0) begin errors++; $display("FAIL reset_rdB got %h exp %h", rdDataB, 64'h0); end
    checks++; if (wrConflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b exp %b", wrConflict, 1'b0); end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    write0 = 1'b1; wrAddr0 = 5'd0; wrData0 = 64'hFFFF;
    write1 = 1'b1; wrAddr1 = 5'd1; wrData1 = 64'hAAAA;
    @(posedge clk); #1;
    idle_inputs();
    rdAddrA = 5'd0; rdAddrB = 5'd1;
    #1;
    checks++; if (rdDataA !== 64'hFFFF) begin errors++; $display("FAIL dual_rdA got %h exp %h", rdDataA, 64'hFFFF); end
    checks++; if (rdDataB !== 64'hAAAA) begin errors++; $display("FAIL dual_rdB got %h exp %h", rdDataB, 64'hAAAA); end
    checks++; if (wrConflict !== 1'b0) begin errors++; $display("FAIL dual_conflict got %b exp %b", wrConflict, 1'b0); end
    rdAddrA = 5'd1; rdAddrB = 5'd1;
    #1;
    checks++; if (rdDataA !== 64'hAAAA) begin errors++; $display("FAIL same_addr_rdA got %h exp %h", rdDataA, 64'hAAAA); end
    checks++; if (rdDataB !== 64'hAAAA) begin errors++; $display("FAIL same_addr_rdB got %h exp %h", rdDataB, 64'hAAAA); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    write0 = 1'b1; wrAddr0 = 5'd2; wrData0 = 64'hCCCC;
    write1 = 1'b1; wrAddr1 = 5'd2; wrData1 = 64'hF0F0;
    @(posedge clk); #1;
    idle_inputs();
    rdAddrA = 5'd2; rdAddrB = 5'd0;
    #1;
    checks++; if (rdDataA !== 64'hF0F0) begin errors++; $display("FAIL collide_data got %h exp %h", rdDataA, 64'hF0F0); end
    checks++; if (wrConflict !== 1'b1) begin errors++; $display("FAIL collide_flag got %b exp %b", wrConflict, 1'b1); end
    checks++; if (rdDataB !== 64'hFFFF) begin errors++; $display("FAIL collide_other got %h exp %h", rdDataB, 64'hFFFF); end
    @(posedge clk); #1;
    checks++; if (wrConflict !== 1'b0) begin errors++; $display("FAIL collide_one_cycle got %b exp %b", wrConflict, 1'b0); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    write0 = 1'b1; wrAddr0 = 5'd31; wrData0 = 64'h1234;
    write1 = 1'b1; wrAddr1 = 5'd31; wrData1 = 64'h5678;
    rdAddrA = 5'd31; rdAddrB = 5'd31;
    #1;
    checks++; if (rdDataA !== 64'h0) begin errors++; $display("FAIL zero_pre_rdA got %h exp %h", rdDataA, 64'h0); end
    checks++; if (rdDataB !== 64'h0) begin errors++; $display("FAIL zero_pre_rdB got %h exp %h", rdDataB, 64'h0); end
    @(posedge clk); #1;
    idle_inputs();
    #1;
    checks++; if (rdDataA !== 64'h0) begin errors++; $display("FAIL zero_post_rdA got %h exp %h", rdDataA, 64'h0); end
    checks++; if (wrConflict !== 1'b1) begin errors++; $display("FAIL zero_conflict got %b exp %b", wrConflict, 1'b1); end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp_pre;
    logic [DATA_W-1:0] exp_prio;
`ifdef REGFILE_BYPASS_EN
    exp_pre  = 64'h9;
    exp_prio = 64'h77;
`else
    exp_pre  = 64'h5;
    exp_prio = 64'h9;
`endif
    @(negedge clk);
    write0 = 1'b1; wrAddr0 = 5'd3; wrData0 = 64'h5;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    write0 = 1'b1; wrAddr0 = 5'd3; wrData0 = 64'h9;
    rdAddrA = 5'd3; rdAddrB = 5'd3;
    #1;
    checks++; if (rdDataA !== exp_pre) begin errors++; $display("FAIL bypass_pre got %h exp %h", rdDataA, exp_pre); end
    @(posedge clk); #1;
    idle_inputs();
    #1;
    checks++; if (rdDataA !== 64'h9) begin errors++; $display("FAIL bypass_post got %h exp %h", rdDataA, 64'h9); end
    // Same-cycle view while both lanes target the read address; nothing is committed.
    write0 = 1'b1; wrAddr0 = 5'd3; wrData0 = 64'h66;
    write1 = 1'b1; wrAddr1 = 5'd3; wrData1 = 64'h77;
    #1;
    checks++; if (rdDataB !== exp_prio) begin errors++; $display("FAIL bypass_lane1_prio got %h exp %h", rdDataB, exp_prio); end
    idle_inputs();
    #1;
  endtask

  task automatic test_clear();
    @(negedge clk);
    clear = 1'b1;
    write0 = 1'b1; wrAddr0 = 5'd3; wrData0 = 64'h44;
    rdAddrA = 5'd3;
    #1;
    checks++; if (rdDataA !== 64'h9) begin errors++; $display("FAIL clear_no_bypass got %h exp %h", rdDataA, 64'h9); end
    wrAddr0 = 5'd4;
    @(posedge clk); #1;
    idle_inputs();
    for (int a = 0; a < 32; a++) begin
      rdAddrA = a[ADDR_W-1:0];
      #1;
      checks++; if (rdDataA !== 64'h0) begin errors++; $display("FAIL clear_addr%0d got %h exp %h", a, rdDataA, 64'h0); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    write0 = 1'b1; wrAddr0 = 5'd0; wrData0 = 64'h7;
    @(posedge clk); #1;
    idle_inputs();
    rdAddrA = 5'd0;
    #1;
    checks++; if (rdDataA !== 64'h7) begin errors++; $display("FAIL reload got %h exp %h", rdDataA, 64'h7); end
    @(negedge clk);
    write0 = 1'b1; wrAddr0 = 5'd0; wrData0 = 64'h8;
    write1 = 1'b1; wrAddr1 = 5'd0; wrData1 = 64'h9;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (rdDataA !== 64'h0) begin errors++; $display("FAIL async_reset_immediate got %h exp %h", rdDataA, 64'h0); end
    @(posedge clk); #1;
    checks++; if (rdDataA !== 64'h0) begin errors++; $display("FAIL reset_blocks_write got %h exp %h", rdDataA, 64'h0); end
    checks++; if (wrConflict !== 1'b0) begin errors++; $display("FAIL reset_blocks_conflict got %b exp %b", wrConflict, 1'b0); end
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdDataA !== 64'h0) begin errors++; $display("FAIL write_lost got %h exp %h", rdDataA, 64'h0); end
  endtask

  initial begin
    rdAddrA = '0; rdAddrB = '0;
    test_reset();
    test_dual_write();
    test_collision();
    test_zero_reg();
    test_bypass();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_2w2r.md
# regfile_2w2r

Parametrised successor to the 32x64 register file: a `NUM_REGS`-deep, `DATA_W`-wide register file with two combinational read ports and two clocked write ports. It includes an optional hardwired-zero register, a synchronous bulk clear, and a registered write-collision flag. It sits in the CPU datapath between decode (read addresses) and writeback (two retire lanes), replacing the single-write-port file.

## Interface
- `DATA_W`, 64, register width in bits
- `ADDR_W`, 5, address width; `NUM_REGS` = 2**`ADDR_W`
- `ZERO_REG`, 1, 1 = register `NUM_REGS`-1 reads as 0 and ignores writes; 0 = ordinary register

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `rdAddrA`  in  `ADDR_W`  read port A address
- `rdDataA`  out  `DATA_W`  read port A data
- `rdAddrB`  in  `ADDR_W`  read port B address
- `rdDataB`  out  `DATA_W`  read port B data
- `write0`  in  1  write enable, lane 0
- `wrAddr0`  in  `ADDR_W`  write address, lane 0
- `wrData0`  in  `DATA_W`  write data, lane 0
- `write1`  in  1  write enable, lane 1
- `wrAddr1`  in  `ADDR_W`  write address, lane 1
- `wrData1`  in  `DATA_W`  write data, lane 1
- `clear`  in  1  synchronous clear of all registers
- `wrConflict`  out  1  registered flag: previous edge had both lanes writing the same address

## Operation
- Storage is `NUM_REGS` x `DATA_W` flops.
- Reset (`reset`=0):
  - All registers go to 0 immediately and `wrConflict` goes to 0.
  - Both `rdData` outputs read 0.
  - Writes and `clear` are ignored while reset is held.
- Rising-edge priority, highest first:
  - `clear`=1: all registers go to 0 and both write lanes are ignored.
  - Else, each lane with `write`=1 updates `wrAddr` with `wrData`.
  - If both lanes target the same address, lane 1 wins.
- When `ZERO_REG`=1:
  - Writes to address `NUM_REGS`-1 are dropped.
  - Reads of that address return 0 regardless of bypass.
- Reads are combinational: `rdDataX` = contents of `rdAddrX`, modified by bypass (see Configuration).
- `wrConflict` is registered each edge as `write0 & write1 & (wrAddr0==wrAddr1)`.
  - Computed even when `clear`=1 or the target is the zero register.
  - Holds for exactly one cycle per colliding edge.
- No internal state machine beyond storage and the `wrConflict` flop. No width conversion: data passes bit-exact.

## Timing
- Write latency: data presented before edge N is readable (non-bypass) immediately after edge N.
- Read latency: 0 cycles, combinational from `rdAddr` and storage.
- `wrConflict` asserts in the cycle after the colliding edge.
- Reset deassertion is asynchronous to `clk`. The first write accepted is at the first rising edge with `reset`=1.
- Reset asserted mid-cycle while a write is pending: the write is lost and the register reads 0.
- Both read ports may address the same register. Both return identical data.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined (write-through forwarding):
  - If `clear`=0, `reset`=1, and a lane writes the address being read, `rdDataX` returns that lane's `wrData` in the same cycle.
  - Lane 1 takes precedence over lane 0.
  - The zero register is never bypassed.
  - `clear`=1 suppresses bypass: reads show current contents.
- Undefined: reads always show stored contents. A same-cycle write becomes visible only after the edge.

## Test plan
- Reset: hold `reset`=0, then release. Read addresses 0 and 30 -> both `rdData` = 0, `wrConflict`=0.
- Dual write and read:
  - Edge 1: lane 0 writes addr 0 = 64'hFFFF, lane 1 writes addr 1 = 64'hAAAA.
  - Then `rdAddrA`=0, `rdAddrB`=1 -> A=64'hFFFF, B=64'hAAAA, `wrConflict`=0.
- Collision: both lanes write addr 2 (lane 0 = 64'hCCCC, lane 1 = 64'hF0F0) -> addr 2 reads 64'hF0F0; `wrConflict`=1 for one cycle only.
- Zero register (`ZERO_REG`=1): write addr 31 = 64'h1234 -> `rdDataA` at addr 31 = 0, before and after the edge, with or without bypass.
- Bypass: addr 3 holds 64'h5, lane 0 writes 64'h9 to addr 3 with `rdAddrA`=3.
  - Before the edge: `rdDataA` = 64'h9 with `REGFILE_BYPASS_EN`, 64'h5 without.
  - After the edge: 64'h9 in both builds.
- Clear and async reset:
  - `clear`=1 together with a lane 0 write to addr 4 -> all registers, including addr 4, read 0 after the edge.
  - Reload addr 0 = 64'h7, then pull `reset` low mid-cycle -> `rdDataA` = 0 immediately, without waiting for a clock edge.
